// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC data-memory responder.
// Holds the responder state encoding, datapath width defaults and the wait
// counter width.
package sisc_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM backing the data memory.
// Ports: clk; we/addr/wdata write port; rdata is the registered read of addr.
// Contents are never cleared by reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write-first is irrelevant here: the read port is never consumed in a write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYC
// wait states, performs a one-cycle array access and returns the response.
// Ports: clk, rst_f (sync, active-low); req_* request handshake
// (req_valid/req_ready, req_we, req_addr, req_wdata); resp_* response
// handshake (resp_valid/resp_ready, resp_rdata, resp_we, resp_err).
// Optional feature macro DMEM_STATS_EN adds rd_cnt/wr_cnt, saturating
// counts of successful loads and stores.
module dmem_resp
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_we,
  output logic              resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_we_q, resp_we_d;
  logic                resp_err_q, resp_err_d;

  logic                in_range_c;
  logic                arr_we_c;
  logic [IDX_W-1:0]    arr_addr_c;
  logic [DATA_W-1:0]   arr_rdata;

  // Full-width range check on the latched address.
  assign in_range_c = ({1'b0, addr_q} < DEPTH_A);

  // Read is launched one cycle ahead so its registered data lands in ACCESS:
  // from the incoming address in IDLE (covers WAIT_CYC=0), else the latched one.
  assign arr_addr_c = (state_q == IDLE) ? req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_c & rst_f),  // a store meeting reset in ACCESS is dropped
    .addr  (arr_addr_c),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_we_d    = resp_we_q;
    resp_err_d   = resp_err_q;
    arr_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(WAIT_CYC);
          state_d = (WAIT_CYC == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        arr_we_c     = in_range_c & we_q;
        resp_err_d   = ~in_range_c;
        resp_we_d    = we_q;
        resp_rdata_d = (in_range_c && !we_q) ? arr_rdata : '0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_we_d    = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_we    = resp_we_q;
  assign resp_err   = resp_err_q;

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  // Saturating counts of in-range accesses.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == ACCESS && in_range_c) begin
      if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Testbench for dmem_resp: two instances (WAIT_CYC=2 and WAIT_CYC=0) driven
// with directed and random load/store traffic, checked against a word-array
// reference model of the memory and the response protocol.
module tb_dmem_resp;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;

  logic          clk;
  logic [1:0]    rst_f;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr   [2];
  logic [DW-1:0] req_wdata  [2];
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [DW-1:0] resp_rdata [2];
  logic [1:0]    resp_we;
  logic [1:0]    resp_err;
`ifdef DMEM_STATS_EN
  logic [15:0]   rd_cnt [2];
  logic [15:0]   wr_cnt [2];
`endif

  int n_tests;
  int n_fail;

  // Reference model: memory contents and successful-access counts per instance.
  logic [DW-1:0] mem_m [2][DEPTH];
  int            rd_m  [2];
  int            wr_m  [2];

  dmem_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYC(2)) u_dut0 (
    .clk(clk), .rst_f(rst_f[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_we(resp_we[0]), .resp_err(resp_err[0])
`ifdef DMEM_STATS_EN
    , .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0])
`endif
  );

  dmem_resp #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYC(0)) u_dut1 (
    .clk(clk), .rst_f(rst_f[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_we(resp_we[1]), .resp_err(resp_err[1])
`ifdef DMEM_STATS_EN
    , .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  task automatic check_counts(input int i, input string tag);
`ifdef DMEM_STATS_EN
    check({tag, "_rd_cnt"}, 32'(rd_cnt[i]), 32'(rd_m[i]));
    check({tag, "_wr_cnt"}, 32'(wr_cnt[i]), 32'(wr_m[i]));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic check_idle(input int i, input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid[i]), 32'd0);
    check({tag, "_req_ready"},  32'(req_ready[i]),  32'd1);
    check({tag, "_rdata"},      resp_rdata[i],      32'd0);
    check({tag, "_we"},         32'(resp_we[i]),    32'd0);
    check({tag, "_err"},        32'(resp_err[i]),   32'd0);
  endtask

  // One full transaction; if ov is set, the next request is presented during
  // the response handshake cycle and must be deferred to the following IDLE.
  task automatic run_txn(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold, input bit ov, input bit ov_we,
                         input logic [AW-1:0] ov_a, input logic [DW-1:0] ov_d);
    bit            err;
    logic [DW-1:0] exp_rd;
    logic [9:0]    idx;
    int            edges;
    err    = (32'(a) >= DEPTH);
    idx    = a[9:0];
    exp_rd = (err || we) ? 32'd0 : mem_m[i][idx];
    drive_req(i, we, a, d);
    resp_ready[i] = (hold == 0);
    check("req_ready_idle", 32'(req_ready[i]), 32'd1);
    step();
    edges = 1;
    req_valid[i] = 1'b0;
    req_we[i]    = 1'($urandom);
    req_addr[i]  = 16'($urandom);
    req_wdata[i] = $urandom;
    check("req_ready_busy", 32'(req_ready[i]), 32'd0);
    while (!resp_valid[i] && edges < 40) begin
      step();
      edges++;
    end
    check("latency", 32'(edges), 32'(wc(i) + 2));
    if (!err) begin
      if (we) begin
        mem_m[i][idx] = d;
        if (wr_m[i] < 65535) wr_m[i]++;
      end else begin
        if (rd_m[i] < 65535) rd_m[i]++;
      end
    end
    check("resp_we",    32'(resp_we[i]),  32'(we));
    check("resp_err",   32'(resp_err[i]), 32'(err));
    check("resp_rdata", resp_rdata[i],    exp_rd);
    check("req_ready_resp", 32'(req_ready[i]), 32'd0);
    check_counts(i, "access");
    for (int h = 0; h < hold; h++) begin
      req_valid[i] = 1'($urandom);
      step();
      check("hold_valid", 32'(resp_valid[i]), 32'd1);
      check("hold_rdata", resp_rdata[i],      exp_rd);
      check("hold_err",   32'(resp_err[i]),   32'(err));
      check("hold_ready", 32'(req_ready[i]),  32'd0);
    end
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    if (ov) drive_req(i, ov_we, ov_a, ov_d);
    step();
    check_idle(i, "handshake");
    resp_ready[i] = 1'b0;
  endtask

  task automatic txn(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    run_txn(i, we, a, d, hold, 1'b0, 1'b0, '0, '0);
  endtask

  // Store then reset, either right after accept (WAIT or ACCESS) or once the
  // response is up (store already committed).
  task automatic reset_mid(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit late);
    int edges;
    drive_req(i, 1'b1, a, d);
    resp_ready[i] = 1'b0;
    step();
    edges = 1;
    req_valid[i] = 1'b0;
    if (late) begin
      while (!resp_valid[i] && edges < 40) begin
        step();
        edges++;
      end
      check("rm_latency", 32'(edges), 32'(wc(i) + 2));
      mem_m[i][a[9:0]] = d;
    end
    rst_f[i] = 1'b0;
    step();
    rst_f[i] = 1'b1;
    rd_m[i] = 0;
    wr_m[i] = 0;
    check_idle(i, "rst_mid");
    check_counts(i, "rst_mid");
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned pick;
    pick = $urandom_range(0, 9);
    if (pick <= 5)      return 16'($urandom_range(0, 31));
    else if (pick == 6) return 16'd1023;
    else if (pick == 7) return 16'd1024;
    else if (pick == 8) return 16'($urandom_range(1025, 65535));
    else                return 16'hFFFF;
  endfunction

  initial begin
    bit            c_we, n_we, ov;
    logic [AW-1:0] c_a, n_a;
    logic [DW-1:0] c_d, n_d;
    n_tests = 0;
    n_fail  = 0;
    rst_f      = 2'b00;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    resp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rd_m[i] = 0;
      wr_m[i] = 0;
    end
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      check_idle(i, "reset");
      check_counts(i, "reset");
    end
    rst_f = 2'b11;

    for (int i = 0; i < 2; i++) begin
      // Give every address the random traffic touches a known value.
      for (int a = 0; a < 32; a++) txn(i, 1'b1, 16'(a), $urandom, 0);
      txn(i, 1'b1, 16'd1023, $urandom, 0);

      txn(i, 1'b1, 16'h0010, 32'hDEADBEEF, 0);
      txn(i, 1'b0, 16'h0010, '0, 0);
      txn(i, 1'b0, 16'h0400, '0, 0);
      txn(i, 1'b0, 16'h0000, '0, 0);
      txn(i, 1'b1, 16'h0400, 32'h12345678, 0);
      txn(i, 1'b0, 16'h0000, '0, 0);
      txn(i, 1'b0, 16'h0010, '0, 5);

      reset_mid(i, 16'h0020, 32'hA5A5_0020, 1'b0);
      txn(i, 1'b0, 16'h0020, '0, 0);
      reset_mid(i, 16'h0021, 32'h5A5A_0021, 1'b1);
      txn(i, 1'b0, 16'h0021, '0, 0);

      // WAIT_CYC=0 stats scenario: 3 stores, 2 loads, one load out of range.
      txn(i, 1'b1, 16'h0003, 32'h0000_0003, 0);
      txn(i, 1'b1, 16'h0004, 32'h0000_0004, 1);
      txn(i, 1'b1, 16'h0005, 32'h0000_0005, 0);
      txn(i, 1'b0, 16'h0004, '0, 0);
      txn(i, 1'b0, 16'h8000, '0, 2);

      // Random traffic with occasional request overlap on the handshake cycle.
      n_we = 1'($urandom);
      n_a  = rand_addr();
      n_d  = $urandom;
      for (int k = 0; k < 80; k++) begin
        c_we = n_we;
        c_a  = n_a;
        c_d  = n_d;
        n_we = 1'($urandom);
        n_a  = rand_addr();
        n_d  = $urandom;
        ov   = ($urandom_range(0, 3) == 0);
        run_txn(i, c_we, c_a, c_d, int'($urandom_range(0, 3)), ov, n_we, n_a, n_d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
